// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: buffers received bytes in a FIFO with host pop, sticky overrun and threshold irq.
// Optional character-timeout interrupt enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_ctrl #(
    parameter int DEPTH          = 8,
    parameter int AW             = 3,
    parameter int THRESH         = 4,
    parameter int TIMEOUT_CYCLES = 4000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_byte,
    input  logic          rx_ready,
    input  logic          rd_en,
    input  logic          clr_ovr,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overrun,
    output logic          irq
);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          rx_q, push_req, push_ok, pop_ok, drop, timeout_flag;
    logic [AW:0]   count_nxt;

    // A pop on a full FIFO frees the slot the coincident push needs.
    assign push_req  = rx_ready & ~rx_q;
    assign pop_ok    = rd_en & ~empty;
    assign push_ok   = push_req & (~full | pop_ok);
    assign drop      = push_req & full & ~pop_ok;
    assign count_nxt = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);

    always_ff @(posedge clk)
        if (push_ok) mem[wptr] <= rx_byte;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            rx_q     <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overrun  <= 1'b0;
            irq      <= 1'b0;
        end else begin
            rx_q     <= rx_ready;
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok) begin
                rptr    <= rptr + 1'b1;
                rd_data <= mem[rptr];
            end
            rd_valid <= pop_ok;
            count    <= count_nxt;
            empty    <= count_nxt == '0;
            full     <= count_nxt == (AW+1)'(DEPTH);
            overrun  <= drop | (overrun & ~clr_ovr);
            irq      <= (count >= (AW+1)'(THRESH)) | overrun | timeout_flag;
        end

`ifdef UART_RX_TIMEOUT_EN
    logic [15:0] idle_cnt;

    // Flag rises on the same edge the idle counter reaches its limit.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            idle_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else if (push_ok | pop_ok | empty) begin
            idle_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            idle_cnt <= (idle_cnt == 16'(TIMEOUT_CYCLES)) ? idle_cnt : idle_cnt + 1'b1;
            if (idle_cnt >= 16'(TIMEOUT_CYCLES - 1)) timeout_flag <= 1'b1;
        end
`else
    assign timeout_flag = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl (DEPTH=8, THRESH=4, TIMEOUT_CYCLES=16).
module tb_uart_rx_ctrl;
    logic       clk = 1'b0, reset = 1'b1;
    logic [7:0] rx_byte = '0;
    logic       rx_ready = 1'b0, rd_en = 1'b0, clr_ovr = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid, empty, full, overrun, irq;
    logic [3:0] count;

    logic [7:0] q[$];
    logic [7:0] last_pop = '0;
    logic       ovr_m = 1'b0;
    int         n_pass = 0, n_chk = 0;

    uart_rx_ctrl #(.DEPTH(8), .AW(3), .THRESH(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_ready(rx_ready),
        .rd_en(rd_en), .clr_ovr(clr_ovr), .rd_data(rd_data), .rd_valid(rd_valid),
        .empty(empty), .full(full), .count(count), .overrun(overrun), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Scoreboard: every rd_valid pulse must match the oldest expected byte.
    always @(negedge clk)
        if (!reset && rd_valid) begin
            if (q.size() == 0) check("rd_spurious", 1, 0);
            else begin
                last_pop = q.pop_front();
                check("rd_data", {24'd0, rd_data}, {24'd0, last_pop});
            end
        end

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte = b; rx_ready = 1'b1;
        if (q.size() < 8) q.push_back(b); else ovr_m = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic pop_byte();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("rd_valid_lat", {31'd0, rd_valid}, 1);
    endtask

    task automatic check_state(input string tag, input logic [3:0] c, input logic ov);
        check({tag, "_count"}, {28'd0, count}, {28'd0, c});
        check({tag, "_empty"}, {31'd0, empty}, {31'd0, c == 4'd0});
        check({tag, "_full"}, {31'd0, full}, {31'd0, c == 4'd8});
        check({tag, "_ovr"}, {31'd0, overrun}, {31'd0, ov});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_state("rst", 4'd0, 1'b0);
        check("rst_irq", {31'd0, irq}, 0);
        check("rst_rdv", {31'd0, rd_valid}, 0);
        check("rst_rdd", {24'd0, rd_data}, 0);
        reset = 1'b0;

        push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
        @(negedge clk);
        check_state("three", 4'd3, 1'b0);
        check("three_irq", {31'd0, irq}, 0);
        repeat (3) pop_byte();
        @(negedge clk);
        check_state("drained", 4'd0, 1'b0);

        for (int i = 0; i < 4; i++) push_byte(8'h10 + 8'(i));
        check("thr_irq_lat", {31'd0, irq}, 0);
        @(negedge clk);
        check("thr_irq", {31'd0, irq}, 1);
        pop_byte();
        check_state("thr_pop", 4'd3, 1'b0);
        @(negedge clk);
        check("thr_irq_clr", {31'd0, irq}, 0);
        repeat (3) pop_byte();

        for (int i = 0; i < 9; i++) push_byte(8'h50 + 8'(i));
        @(negedge clk);
        check_state("ovf", 4'd8, ovr_m);
        check("ovf_irq", {31'd0, irq}, 1);
        @(negedge clk); clr_ovr = 1'b1;
        @(negedge clk); clr_ovr = 1'b0;
        ovr_m = 1'b0;
        check("clr_ovr", {31'd0, overrun}, 0);

        @(negedge clk);
        rx_byte = 8'h60; rx_ready = 1'b1; rd_en = 1'b1;
        q.push_back(8'h60);
        @(negedge clk);
        rx_ready = 1'b0; rd_en = 1'b0;
        check("fullpp_rdv", {31'd0, rd_valid}, 1);
        check_state("fullpp", 4'd8, 1'b0);
        repeat (8) pop_byte();
        @(negedge clk);
        check_state("drain8", 4'd0, 1'b0);

        @(negedge clk);
        rx_byte = 8'h77; rx_ready = 1'b1; q.push_back(8'h77);
        repeat (20) @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
        check_state("held", 4'd1, 1'b0);
        pop_byte();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("empty_rdv", {31'd0, rd_valid}, 0);
        check("empty_rdd", {24'd0, rd_data}, 32'h77);
        check("empty_last", {24'd0, last_pop}, 32'h77);

        push_byte(8'h88);
        repeat (24) @(negedge clk);
`ifdef UART_RX_TIMEOUT_EN
        check("timeout_irq", {31'd0, irq}, 1);
`else
        check("timeout_irq", {31'd0, irq}, 0);
`endif
        pop_byte();
        @(negedge clk);
        check("timeout_clr", {31'd0, irq}, 0);

        for (int i = 0; i < 5; i++) push_byte(8'hA0 + 8'(i));
        @(negedge clk);
        check_state("pre_rst", 4'd5, 1'b0);
        reset = 1'b1;
        q.delete();
        #1;
        check_state("mid_rst", 4'd0, 1'b0);
        check("mid_rst_irq", {31'd0, irq}, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_state("post_rst", 4'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
